// File: rtl/ed25519_pow_modp.sv
// ed25519_pow_modp: y = x^e mod p, p = 2^255-19, by left-to-right
// square-and-multiply on an external modular multiplier.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           request handshake; in_x base, in_e exponent, in_tag tag
//   out_valid/out_ready         response handshake; out_y canonical result, out_tag echoed tag
//   busy                        high from accept until the response is consumed
//   mul_in0/mul_in1/mul_m_i     operands and {epoch, valid} issued to the multiplier
//   mul_out0/mul_m_o            canonical product and returned metadata
module ed25519_pow_modp #(
    parameter int unsigned EW = 255,
    parameter int unsigned TW = 8,
    parameter int unsigned M  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [254:0]  in_x,
    input  logic [EW-1:0] in_e,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [254:0]  out_y,
    output logic [TW-1:0] out_tag,
    output logic          busy,
    output logic [254:0]  mul_in0,
    output logic [254:0]  mul_in1,
    output logic [M-1:0]  mul_m_i,
    input  logic [M-1:0]  mul_m_o,
    input  logic [254:0]  mul_out0
);

    localparam int unsigned FW = 255;
    localparam int unsigned IW = (EW > 1) ? $clog2(EW) : 1;
    localparam logic [FW-1:0] P   = {FW{1'b1}} - FW'(18);
    localparam logic [FW-1:0] ONE = FW'(1);

    typedef enum logic [2:0] {IDLE, SCAN, SQR, WSQR, MUL, WMUL, DONE} state_t;

    state_t          state, state_d;
    logic [IW-1:0]   idx, idx_d;
    logic [EW-1:0]   e_q, e_d;
    logic [TW-1:0]   tag_q, tag_d;
    logic [FW-1:0]   xr, xr_d;
    logic [FW-1:0]   r, r_d;
    logic            epoch, epoch_d;
    logic            in_ready_d, out_valid_d, busy_d;
    logic [FW-1:0]   out_y_d, mul_in0_d, mul_in1_d;
    logic [TW-1:0]   out_tag_d;
    logic [M-1:0]    mul_m_i_d;
    logic            ret_match;

    // A return is only ours if it is valid and carries the current epoch.
    assign ret_match = mul_m_o[0] && (mul_m_o[1] == epoch);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            e_q       <= '0;
            tag_q     <= '0;
            xr        <= '0;
            r         <= '0;
            epoch     <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_tag   <= '0;
            busy      <= 1'b0;
            mul_in0   <= '0;
            mul_in1   <= '0;
            mul_m_i   <= '0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            e_q       <= e_d;
            tag_q     <= tag_d;
            xr        <= xr_d;
            r         <= r_d;
            epoch     <= epoch_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_y     <= out_y_d;
            out_tag   <= out_tag_d;
            busy      <= busy_d;
            mul_in0   <= mul_in0_d;
            mul_in1   <= mul_in1_d;
            mul_m_i   <= mul_m_i_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        idx_d       = idx;
        e_d         = e_q;
        tag_d       = tag_q;
        xr_d        = xr;
        r_d         = r;
        epoch_d     = epoch;
        out_valid_d = out_valid;
        out_y_d     = out_y;
        out_tag_d   = out_tag;
        busy_d      = busy;
        mul_in0_d   = mul_in0;
        mul_in1_d   = mul_in1;
        mul_m_i_d   = '0;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    e_d     = in_e;
                    tag_d   = in_tag;
                    // in_x < 2^255 < 2p, so a single conditional subtract canonicalises it
                    xr_d    = (in_x >= P) ? (in_x - P) : in_x;
                    idx_d   = IW'(EW - 1);
                    r_d     = ONE;
                    epoch_d = ~epoch;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            // Leading-zero skip; the first set bit loads r = x without a multiply.
            SCAN: begin
                if (e_q[idx]) begin
                    r_d = xr;
                    if (idx == '0) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx - IW'(1);
                        state_d = SQR;
                    end
                end else if (idx == '0) begin
                    r_d     = ONE;
                    state_d = DONE;
                end else begin
                    idx_d = idx - IW'(1);
                end
            end
            SQR: begin
                mul_in0_d = r;
                mul_in1_d = r;
                mul_m_i_d = M'({epoch, 1'b1});
                state_d   = WSQR;
            end
            WSQR: begin
                if (ret_match) begin
                    r_d = mul_out0;
                    if (e_q[idx]) begin
                        state_d = MUL;
                    end else if (idx == '0) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx - IW'(1);
                        state_d = SQR;
                    end
                end
            end
            MUL: begin
                mul_in0_d = r;
                mul_in1_d = xr;
                mul_m_i_d = M'({epoch, 1'b1});
                state_d   = WMUL;
            end
            WMUL: begin
                if (ret_match) begin
                    r_d = mul_out0;
                    if (idx == '0) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx - IW'(1);
                        state_d = SQR;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Present the result on the same edge that enters DONE.
        if ((state != DONE) && (state_d == DONE)) begin
            out_valid_d = 1'b1;
            out_y_d     = r_d;
            out_tag_d   = tag_q;
        end

        in_ready_d = (state_d == IDLE);
    end

endmodule

// File: tb/tb_ed25519_pow_modp.sv
// tb_ed25519_pow_modp: directed and randomised checks of ed25519_pow_modp
// against a behavioural variable-latency multiplier and a golden pow model.
module tb_ed25519_pow_modp;

    localparam int unsigned EW = 255;
    localparam int unsigned TW = 8;
    localparam int unsigned M  = 2;
    localparam logic [254:0] P = {255{1'b1}} - 255'd18;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [254:0]  in_x      = '0;
    logic [EW-1:0] in_e      = '0;
    logic [TW-1:0] in_tag    = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [254:0]  out_y;
    logic [TW-1:0] out_tag;
    logic          busy;
    logic [254:0]  mul_in0;
    logic [254:0]  mul_in1;
    logic [M-1:0]  mul_m_i;
    logic [M-1:0]  mul_m_o   = '0;
    logic [254:0]  mul_out0  = '0;

    always #5 clk = ~clk;

    ed25519_pow_modp #(.EW(EW), .TW(TW), .M(M)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_e(in_e), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_tag(out_tag), .busy(busy),
        .mul_in0(mul_in0), .mul_in1(mul_in1), .mul_m_i(mul_m_i),
        .mul_m_o(mul_m_o), .mul_out0(mul_out0)
    );

    int tests = 0;
    int fails = 0;

    function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
        logic [511:0] t;
        t = {257'd0, a} * {257'd0, b};
        t = t % {257'd0, P};
        return t[254:0];
    endfunction

    function automatic logic [254:0] powmod(input logic [254:0] x, input logic [EW-1:0] e);
        logic [254:0] r;
        r = 255'd1;
        for (int i = EW - 1; i >= 0; i--) begin
            r = mulmod(r, r);
            if (e[i]) r = mulmod(r, x);
        end
        return r;
    endfunction

    function automatic int mulcount(input logic [EW-1:0] e);
        int msb;
        int pc;
        msb = -1;
        pc  = 0;
        for (int i = 0; i < EW; i++) begin
            if (e[i]) begin
                msb = i;
                pc++;
            end
        end
        return (msb < 0) ? 0 : (msb + pc - 1);
    endfunction

    task automatic check(input string name, input logic [254:0] got, input logic [254:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    // Multiplier model: in-order, latency drawn from [lat_min, lat_max], never flushed by reset.
    typedef struct {
        logic [254:0] prod;
        logic [M-1:0] meta;
        longint       due;
    } mq_t;

    mq_t    mq[$];
    longint cyc         = 0;
    longint last_due    = 0;
    int     lat_min     = 1;
    int     lat_max     = 1;
    int     issues      = 0;
    int     overlap     = 0;
    bit     outstanding = 1'b0;

    always @(negedge clk) begin
        mq_t ent;
        cyc++;
        mul_m_o = '0;
        if (!rst_n) outstanding = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            mul_m_o  = mq[0].meta;
            mul_out0 = mq[0].prod;
            mq.delete(0);
            outstanding = 1'b0;
        end
        if (mul_m_i[0]) begin
            issues++;
            if (outstanding) overlap++;
            outstanding = 1'b1;
            ent.prod = mulmod(mul_in0, mul_in1);
            ent.meta = mul_m_i;
            ent.due  = cyc + longint'($urandom_range(lat_max, lat_min));
            if (ent.due <= last_due) ent.due = last_due + 1;
            last_due = ent.due;
            mq.push_back(ent);
        end
    end

    task automatic send(input logic [254:0] x, input logic [EW-1:0] e, input logic [TW-1:0] tag);
        int n;
        n = 0;
        in_x = x;
        in_e = e;
        in_tag = tag;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept", 255'(n < 200), 255'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic recv(input string name, input logic [254:0] exp_y, input logic [TW-1:0] exp_tag,
                        input int budget, input bit rnd);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (n < budget) begin
            out_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            if (out_valid && out_ready) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        check({name, "_done"}, 255'(got), 255'd1);
        check({name, "_y"}, out_y, exp_y);
        check({name, "_tag"}, 255'(out_tag), 255'(exp_tag));
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int            n0;
        int            n;
        int            bad;
        logic [254:0]  y0;
        logic [TW-1:0] t0;
        logic [255:0]  rx;
        logic [255:0]  re;
        logic [EW-1:0] e;
        logic [254:0]  x;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 255'(in_ready), 255'd0);
        check("rst_out_valid", 255'(out_valid), 255'd0);
        check("rst_busy", 255'(busy), 255'd0);
        check("rst_out_y", out_y, 255'd0);
        check("rst_mul_m_i", 255'(mul_m_i), 255'd0);
        check("rst_mul_in0", mul_in0, 255'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready_up", 255'(in_ready), 255'd1);

        // 1: 2^3 with one square and one multiply
        lat_min = 3; lat_max = 3;
        n0 = issues;
        send(255'd2, EW'(3), 8'h5A);
        check("t1_busy", 255'(busy), 255'd1);
        recv("t1", 255'd8, 8'h5A, 1000, 1'b0);
        check("t1_muls", 255'(issues - n0), 255'd2);

        // 2: zero exponent and zero base corners
        n0 = issues;
        send(255'd0, EW'(0), 8'h01);
        recv("t2a", 255'd1, 8'h01, 1000, 1'b0);
        check("t2a_muls", 255'(issues - n0), 255'd0);
        send(255'd7, EW'(0), 8'h02);
        recv("t2b", 255'd1, 8'h02, 1000, 1'b0);
        send(255'd0, EW'(5), 8'h03);
        recv("t2c", 255'd0, 8'h03, 1000, 1'b0);

        // 3: inversion of 2, and a non-canonical base
        lat_min = 1; lat_max = 1;
        n0 = issues;
        send(255'd2, EW'(P - 255'd2), 8'h33);
        recv("t3a", {1'b0, {254{1'b1}}} - 255'd8, 8'h33, 20000, 1'b0);
        check("t3a_muls", 255'(issues - n0), 255'd506);
        n0 = issues;
        send(P + 255'd3, EW'(1), 8'h34);
        recv("t3b", 255'd3, 8'h34, 1000, 1'b0);
        check("t3b_muls", 255'(issues - n0), 255'd0);

        // 4: back-pressure holds the response
        send(255'd3, EW'(5), 8'hC3);
        n = 0;
        while (!out_valid && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("t4_valid", 255'(out_valid), 255'd1);
        check("t4_y", out_y, 255'd243);
        y0 = out_y;
        t0 = out_tag;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (out_y !== y0 || out_tag !== t0 || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1)
                bad++;
        end
        check("t4_hold", 255'(bad), 255'd0);
        check("t4_tag", 255'(out_tag), 255'(8'hC3));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("t4_valid_drop", 255'(out_valid), 255'd0);
        check("t4_busy_drop", 255'(busy), 255'd0);
        check("t4_ready_up", 255'(in_ready), 255'd1);

        // 5: reset while a square is in flight; this is the eighth request, so it runs on epoch 0
        lat_min = 300; lat_max = 300;
        n0 = issues;
        send(255'd3, EW'(8'hFF), 8'h11);
        n = 0;
        while (issues == n0 && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_issued", 255'(issues - n0), 255'd1);
        lat_min = 2; lat_max = 2;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 255'(busy), 255'd0);
        check("t5_rst_ready", 255'(in_ready), 255'd0);
        check("t5_rst_mi", 255'(mul_m_i), 255'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(255'd5, EW'(2), 8'h22);
        recv("t5", 255'd25, 8'h22, 2000, 1'b0);

        // 6: random base/exponent, random latency and back-pressure
        lat_min = 1; lat_max = 40;
        for (int k = 0; k < 5; k++) begin
            for (int w = 0; w < 8; w++) begin
                rx = {rx[223:0], $urandom()};
                re = {re[223:0], $urandom()};
            end
            x = rx[254:0];
            e = (k < 4) ? EW'(re[23:0]) : EW'(re);
            n0 = issues;
            send(x, e, TW'(8'h60 + k));
            recv($sformatf("t6_%0d", k), powmod(x, e), TW'(8'h60 + k), 40000, 1'b1);
            check($sformatf("t6_%0d_muls", k), 255'(issues - n0), 255'(mulcount(e)));
        end
        check("one_outstanding", 255'(overlap), 255'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
